// File: rtl/ack_wait_fsm_pkg.sv
// ack_wait_fsm_pkg: shared types and helpers for the ACK wait tracker and its match compare
package ack_wait_fsm_pkg;
  localparam int NODE_ID_W = 8;
  localparam int PKT_ID_W = 8;
  typedef logic [NODE_ID_W-1:0] node_id_t;
  typedef logic [PKT_ID_W-1:0] packet_id_t;
  typedef enum logic [1:0] {IDLE, WAIT, RETX, DONE} ack_wait_state_e;
  // counter width for values 0..n-1, never narrower than one bit
  function automatic int cnt_w(input int n);
    return n < 2 ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/ack_wait_fsm_match.sv
// ack_match_comb: combinational check that a decoded header is the ACK for a tracked packet
// Ports: rx_* decoded header fields, exp_src_id/exp_packet_id tracked packet, own_id local node, match result
module ack_match_comb #(
  parameter int NODE_ID_W = 8,
  parameter int PKT_ID_W = 8
) (
  input  logic                 rx_valid,
  input  logic                 rx_is_ack,
  input  logic [NODE_ID_W-1:0] rx_src_id,
  input  logic [NODE_ID_W-1:0] rx_dst_id,
  input  logic [PKT_ID_W-1:0]  rx_packet_id,
  input  logic [NODE_ID_W-1:0] exp_src_id,
  input  logic [NODE_ID_W-1:0] own_id,
  input  logic [PKT_ID_W-1:0]  exp_packet_id,
  output logic                 match
);
  assign match = rx_valid & rx_is_ack & (rx_src_id == exp_src_id) & (rx_dst_id == own_id) &
                 (rx_packet_id == exp_packet_id);
endmodule

// File: rtl/ack_wait_fsm.sv
// ack_wait_fsm: tracks a sent packet until its ACK arrives, retransmitting on timeout up to a retry limit
// Ports: req_* tracking request in, rx_* decoded header monitor, retx_* retransmit request out,
//        done_* one-cycle completion report, busy while a packet is tracked
module ack_wait_fsm
  import ack_wait_fsm_pkg::*;
#(
  parameter int NODE_ID_W = ack_wait_fsm_pkg::NODE_ID_W,
  parameter int PKT_ID_W = ack_wait_fsm_pkg::PKT_ID_W,
  parameter int TIMEOUT_CYCLES = 256,
  parameter int MAX_RETRY = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NODE_ID_W-1:0] this_node_id,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [NODE_ID_W-1:0] req_dst_id,
  input  logic [PKT_ID_W-1:0]  req_packet_id,
  input  logic                 rx_valid,
  output logic                 rx_ready,
  input  logic                 rx_is_ack,
  input  logic [NODE_ID_W-1:0] rx_src_id,
  input  logic [NODE_ID_W-1:0] rx_dst_id,
  input  logic [PKT_ID_W-1:0]  rx_packet_id,
  output logic                 retx_valid,
  input  logic                 retx_ready,
  output logic [NODE_ID_W-1:0] retx_dst_id,
  output logic [PKT_ID_W-1:0]  retx_packet_id,
  output logic                 done_valid,
  output logic                 done_ok,
  output logic [PKT_ID_W-1:0]  done_packet_id,
  output logic                 busy
);
  localparam int TW = cnt_w(TIMEOUT_CYCLES + 1);
  localparam int RW = cnt_w(MAX_RETRY + 1);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [RW-1:0] R_MAX = RW'(MAX_RETRY);
  ack_wait_state_e state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [RW-1:0] retry_q, retry_d;
  logic ack_seen_q, ack_seen_d, ok_q, ok_d, match;
  logic [NODE_ID_W-1:0] dst_q, dst_d;
  logic [PKT_ID_W-1:0] id_q, id_d;
  ack_match_comb #(.NODE_ID_W(NODE_ID_W), .PKT_ID_W(PKT_ID_W)) u_match (
    .rx_valid(rx_valid), .rx_is_ack(rx_is_ack), .rx_src_id(rx_src_id), .rx_dst_id(rx_dst_id),
    .rx_packet_id(rx_packet_id), .exp_src_id(dst_q), .own_id(this_node_id),
    .exp_packet_id(id_q), .match(match)
  );
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      timer_q <= '0;
      retry_q <= '0;
      ack_seen_q <= 1'b0;
      ok_q <= 1'b0;
      dst_q <= '0;
      id_q <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      retry_q <= retry_d;
      ack_seen_q <= ack_seen_d;
      ok_q <= ok_d;
      dst_q <= dst_d;
      id_q <= id_d;
    end
  end
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    retry_d = retry_q;
    ack_seen_d = ack_seen_q;
    ok_d = ok_q;
    dst_d = dst_q;
    id_d = id_q;
    case (state_q)
      IDLE: if (req_valid) begin
        state_d = WAIT;
        dst_d = req_dst_id;
        id_d = req_packet_id;
        timer_d = '0;
        retry_d = '0;
        ack_seen_d = 1'b0;
      end
      // a match wins over a timeout landing in the same cycle
      WAIT: if (match) begin
        state_d = DONE;
        ok_d = 1'b1;
      end else if (timer_q == T_LAST) begin
        state_d = retry_q == R_MAX ? DONE : RETX;
        ok_d = 1'b0;
      end else begin
        timer_d = timer_q + 1'b1;
      end
      // an ACK seen while the retransmit is pending, even on the handshake cycle, completes the packet
      RETX: begin
        ack_seen_d = ack_seen_q | match;
        if (retx_ready) begin
          state_d = ack_seen_d ? DONE : WAIT;
          ok_d = ack_seen_d;
          retry_d = ack_seen_d ? retry_q : retry_q + 1'b1;
          timer_d = '0;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  assign req_ready = state_q == IDLE;
  assign busy = state_q != IDLE;
  assign rx_ready = 1'b1;
  assign retx_valid = state_q == RETX;
  assign retx_dst_id = dst_q;
  assign retx_packet_id = id_q;
  assign done_valid = state_q == DONE;
  assign done_ok = done_valid & ok_q;
  assign done_packet_id = id_q;
endmodule

// File: tb/tb_ack_wait_fsm.sv
// tb_ack_wait_fsm: directed bench with a cycle-level reference model and literal checks
module tb_ack_wait_fsm;
  localparam int T = 8;
  localparam int MAXR = 2;
  localparam logic [7:0] NODE = 8'h01;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [7:0] this_node_id = NODE;
  logic req_valid = 0, req_ready, rx_valid = 0, rx_ready, rx_is_ack = 0;
  logic [7:0] req_dst_id = 0, req_packet_id = 0, rx_src_id = 0, rx_dst_id = 0, rx_packet_id = 0;
  logic retx_valid, retx_ready = 1'b1, done_valid, done_ok, busy;
  logic [7:0] retx_dst_id, retx_packet_id, done_packet_id;
  int tests = 0, fails = 0, retx_cnt = 0, done_cnt = 0, n, snap;
  ack_wait_fsm #(.NODE_ID_W(8), .PKT_ID_W(8), .TIMEOUT_CYCLES(T), .MAX_RETRY(MAXR)) dut (
    .clk(clk), .rst_n(rst_n), .this_node_id(this_node_id), .req_valid(req_valid),
    .req_ready(req_ready), .req_dst_id(req_dst_id), .req_packet_id(req_packet_id),
    .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_is_ack(rx_is_ack), .rx_src_id(rx_src_id),
    .rx_dst_id(rx_dst_id), .rx_packet_id(rx_packet_id), .retx_valid(retx_valid),
    .retx_ready(retx_ready), .retx_dst_id(retx_dst_id), .retx_packet_id(retx_packet_id),
    .done_valid(done_valid), .done_ok(done_ok), .done_packet_id(done_packet_id), .busy(busy)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  // reference model: packet lifecycle in terms of remaining wait cycles and retries used
  bit armed = 0, m_trk = 0, m_retx = 0, m_done = 0, m_ok = 0, m_acked = 0;
  int m_left = 0, m_tries = 0;
  logic [7:0] m_dst = 0, m_id = 0;
  task automatic fin(input bit ok);
    m_trk = 0;
    m_retx = 0;
    m_done = 1;
    m_ok = ok;
  endtask
  always @(posedge clk) begin : model
    bit hit;
    hit = rx_valid && rx_is_ack && rx_src_id == m_dst && rx_dst_id == NODE && rx_packet_id == m_id;
    armed = 1;
    if (!rst_n) begin
      m_trk = 0; m_retx = 0; m_done = 0; m_ok = 0;
    end else if (m_done) m_done = 0;
    else if (!m_trk) begin
      if (req_valid) begin
        m_trk = 1; m_dst = req_dst_id; m_id = req_packet_id; m_left = T; m_tries = 0; m_acked = 0;
      end
    end else if (m_retx) begin
      m_acked |= hit;
      if (retx_ready) begin
        if (m_acked) fin(1);
        else begin
          m_retx = 0; m_tries++; m_left = T;
        end
      end
    end else if (hit) fin(1);
    else begin
      m_left--;
      if (m_left == 0) begin
        if (m_tries == MAXR) fin(0);
        else m_retx = 1;
      end
    end
  end
  always @(negedge clk) if (armed) begin
    chk("req_ready", req_ready, !m_trk && !m_done);
    chk("busy", busy, m_trk || m_done);
    chk("rx_ready", rx_ready, 1);
    chk("retx_valid", retx_valid, m_retx);
    chk("done_valid", done_valid, m_done);
    chk("done_ok", done_ok, m_done && m_ok);
    if (m_done) chk("done_packet_id", done_packet_id, m_id);
    if (m_retx) begin
      chk("retx_dst_id", retx_dst_id, m_dst);
      chk("retx_packet_id", retx_packet_id, m_id);
    end
    if (retx_valid && retx_ready) retx_cnt++;
    if (done_valid) done_cnt++;
  end
  task automatic step(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask
  task automatic send_req(input logic [7:0] dst, input logic [7:0] id);
    req_valid = 1; req_dst_id = dst; req_packet_id = id;
    step(1);
    req_valid = 0;
  endtask
  task automatic hdr(input logic ack, input logic [7:0] s, input logic [7:0] d, input logic [7:0] id);
    rx_valid = 1; rx_is_ack = ack; rx_src_id = s; rx_dst_id = d; rx_packet_id = id;
    step(1);
    rx_valid = 0;
  endtask
  task automatic wait_done(output int c);
    c = 0;
    while (!done_valid && c < 100) begin step(1); c++; end
    chk("done_seen", done_valid, 1);
  endtask
  task automatic wait_retx(output int c);
    c = 0;
    while (!retx_valid && c < 100) begin step(1); c++; end
    chk("retx_seen", retx_valid, 1);
  endtask
  initial begin
    step(2);
    chk("rst req_ready", req_ready, 1);
    chk("rst busy", busy, 0);
    chk("rst retx_valid", retx_valid, 0);
    chk("rst done_valid", done_valid, 0);
    rst_n = 1;
    step(1);
    // happy path: ACK in the 3rd WAIT cycle
    retx_cnt = 0;
    send_req(8'h05, 8'h3A);
    step(2);
    hdr(1, 8'h05, 8'h01, 8'h3A);
    chk("happy done_valid", done_valid, 1);
    chk("happy done_ok", done_ok, 1);
    chk("happy done_id", done_packet_id, 8'h3A);
    chk("happy retx_cnt", retx_cnt, 0);
    step(2);
    // full timeout: three 8-cycle waits with two retransmits in between
    retx_cnt = 0;
    send_req(8'h05, 8'h3A);
    wait_done(n);
    chk("timeout cycles", n, 26);
    chk("timeout done_ok", done_ok, 0);
    chk("timeout retx_cnt", retx_cnt, 2);
    step(2);
    // mismatched ACKs ignored, correct ACK in the 2nd WAIT
    retx_cnt = 0;
    send_req(8'h05, 8'h3A);
    hdr(1, 8'h05, 8'h01, 8'h3B);
    hdr(1, 8'h06, 8'h01, 8'h3A);
    hdr(1, 8'h05, 8'h02, 8'h3A);
    hdr(0, 8'h05, 8'h01, 8'h3A);
    wait_retx(n);
    chk("mismatch retx wait", n, 4);
    step(2);
    hdr(1, 8'h05, 8'h01, 8'h3A);
    chk("mismatch done_ok", done_ok, 1);
    chk("mismatch retx_cnt", retx_cnt, 1);
    step(2);
    // backpressure with an ACK landing while retransmit is held
    retx_cnt = 0;
    retx_ready = 0;
    send_req(8'h05, 8'h3A);
    wait_retx(n);
    for (int i = 0; i < 5; i++) begin
      chk("bp retx_valid", retx_valid, 1);
      chk("bp retx_dst", retx_dst_id, 8'h05);
      chk("bp retx_id", retx_packet_id, 8'h3A);
      rx_valid = (i == 2); rx_is_ack = 1; rx_src_id = 8'h05; rx_dst_id = 8'h01; rx_packet_id = 8'h3A;
      step(1);
    end
    rx_valid = 0;
    retx_ready = 1;
    chk("bp held", retx_valid, 1);
    step(1);
    chk("bp done_valid", done_valid, 1);
    chk("bp done_ok", done_ok, 1);
    chk("bp retx_cnt", retx_cnt, 1);
    step(2);
    // ACK in the final WAIT cycle still succeeds
    retx_cnt = 0;
    send_req(8'h05, 8'h3A);
    step(7);
    hdr(1, 8'h05, 8'h01, 8'h3A);
    chk("last done_valid", done_valid, 1);
    chk("last done_ok", done_ok, 1);
    chk("last retx_cnt", retx_cnt, 0);
    step(2);
    // reset mid-WAIT, then a normal request
    snap = done_cnt;
    send_req(8'h05, 8'h3A);
    step(3);
    rst_n = 0;
    step(1);
    chk("midrst busy", busy, 0);
    chk("midrst req_ready", req_ready, 1);
    chk("midrst done_valid", done_valid, 0);
    rst_n = 1;
    step(3);
    chk("midrst no done", done_cnt, snap);
    send_req(8'h05, 8'h44);
    hdr(1, 8'h05, 8'h01, 8'h44);
    chk("post done_ok", done_ok, 1);
    chk("post done_id", done_packet_id, 8'h44);
    step(2);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/ack_wait_fsm.md
Name: ack_wait_fsm

Overview:
- Sender-side counterpart of ACK generation: after a data packet is transmitted, tracks that packet and watches decoded incoming headers for the matching ACK.
- Requests retransmission on timeout, up to a retry limit, then reports success or failure.
- Sits between the packet transmit path (request/retransmit) and the receive header decoder (ACK monitor).

Parameters:
NODE_ID_W, 8, width of node id fields
PKT_ID_W, 8, width of packet id
TIMEOUT_CYCLES, 256, WAIT cycles before a timeout (>=1)
MAX_RETRY, 3, retransmissions allowed before failure (>=0)

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
this_node_id  in  NODE_ID_W  own node id
req_valid  in  1  sent packet needs ACK tracking
req_ready  out  1  ready to accept a tracking request
req_dst_id  in  NODE_ID_W  destination of the sent packet
req_packet_id  in  PKT_ID_W  id of the sent packet
rx_valid  in  1  decoded header valid
rx_ready  out  1  constant 1; monitor never stalls
rx_is_ack  in  1  header is an ACK
rx_src_id  in  NODE_ID_W  header source
rx_dst_id  in  NODE_ID_W  header destination
rx_packet_id  in  PKT_ID_W  header packet id
retx_valid  out  1  retransmit request
retx_ready  in  1  transmitter accepts retransmit
retx_dst_id  out  NODE_ID_W  latched destination
retx_packet_id  out  PKT_ID_W  latched packet id
done_valid  out  1  one-cycle completion pulse
done_ok  out  1  1 = ACKed, 0 = retries exhausted
done_packet_id  out  PKT_ID_W  id of the completed packet
busy  out  1  state != IDLE

Behaviour:
- All registers sample on posedge clk.
- rst_n=0 at any edge forces IDLE and clears timer, retry, ack_seen and latched ids. Outputs after reset: req_ready=1, everything else 0. A reset mid-operation emits no done pulse.
- match = rx_valid & rx_is_ack & rx_src_id==latched dst & rx_dst_id==this_node_id & rx_packet_id==latched id.
- IDLE:
  - req_ready=1.
  - On req_valid: latch dst/id, timer=0, retry=0, ack_seen=0, go to WAIT.
  - rx ignored.
- WAIT:
  - match -> DONE with ok=1. Match has priority over a timeout in the same cycle.
  - Otherwise, if timer==TIMEOUT_CYCLES-1: retry==MAX_RETRY -> DONE with ok=0; else -> RETX.
  - Otherwise timer+1.
  - WAIT lasts exactly TIMEOUT_CYCLES cycles; an ACK in the final cycle succeeds.
- RETX:
  - retx_valid=1 with latched dst/id.
  - Once asserted, retx_valid and its data stay stable until retx_ready.
  - A match during RETX (including the handshake cycle) sets ack_seen.
  - On handshake: ack_seen -> DONE with ok=1; else retry+1, timer=0 -> WAIT.
- DONE:
  - done_valid=1 for exactly one cycle, with done_ok and done_packet_id = latched id.
  - req_ready=0; next state is IDLE.
  - done_valid therefore follows the deciding cycle by 1 clock.
- Non-ACK headers and mismatched ACKs are ignored in every state. Packet id compare is exact and does not wrap.
- Widths:
  - timer = $clog2(TIMEOUT_CYCLES+1).
  - retry = $clog2(MAX_RETRY+1).
  - No counter ever exceeds its terminal value.
- MAX_RETRY=0: first timeout goes directly to DONE with ok=0; retx_valid never asserts.

Decomposition:
- types package: node_id_t, packet_id_t, ack_wait_state_e {IDLE, WAIT, RETX, DONE}.
- Sub-module ack_match_comb: purely combinational match compare, reusable by other ACK consumers.

Test Plan (TIMEOUT_CYCLES=8, MAX_RETRY=2, this_node_id=0x01):
- Reset: hold rst_n=0 for 2 cycles -> req_ready=1, busy=0, retx_valid=0, done_valid=0.
- Happy path: req dst=0x05 id=0x3A, then ACK src=0x05 dst=0x01 id=0x3A in the 3rd WAIT cycle -> next cycle done_valid=1, done_ok=1, done_packet_id=0x3A; retx_valid never asserts.
- Timeout (retx_ready=1, no ACK) -> retx pulses after WAIT cycles 8 and 16 (dst 0x05, id 0x3A); after the 3rd 8-cycle WAIT, done_ok=0.
- Mismatched ACKs (id 0x3B, src 0x06, dst 0x02) are ignored and a timeout occurs; then a correct ACK in the 2nd WAIT -> done_ok=1 after exactly 1 retransmit.
- Backpressure: retx_ready low for 5 cycles -> retx_valid/ids stable; a matching ACK in cycle 3, then handshake -> DONE ok=1, no return to WAIT.
- Corner cases:
  - ACK coincident with the 8th WAIT cycle -> ok=1, no retx.
  - rst_n=0 during WAIT -> IDLE, no done pulse; a subsequent request works normally.
